// File: rtl/debug_pkg.sv
// -----------------------------------------------------------------------------
// debug_pkg
// Shared definitions for the debug hart controller: FSM state encoding,
// abstract-register numbers, dcsr field positions, halt cause codes and small
// regno decode helpers.
// Optional feature macro: DEBUG_HART_STEP_EN adds the single-step state.
// -----------------------------------------------------------------------------
package debug_pkg;

    typedef enum logic [2:0] {
        ST_RUN       = 3'd0,
        ST_HALTING   = 3'd1,
        ST_HALT      = 3'd2,
        ST_RESUMING  = 3'd3
`ifdef DEBUG_HART_STEP_EN
        , ST_STEP    = 3'd4
`endif
    } hart_state_e;

    localparam logic [15:0] REG_MISA      = 16'h0301;
    localparam logic [15:0] REG_DCSR      = 16'h07B0;
    localparam logic [15:0] REG_DPC       = 16'h07B1;
    localparam logic [15:0] REG_DSCRATCH0 = 16'h07B2;
    localparam logic [15:0] GPR_BASE      = 16'h1000;

    localparam int          DCSR_VER_LSB   = 28;
    localparam int          DCSR_CAUSE_LSB = 6;
    localparam int          DCSR_STEP_BIT  = 2;
    localparam int          DCSR_PRV_LSB   = 0;
    localparam logic [3:0]  DCSR_XDEBUGVER = 4'd4;

    localparam logic [2:0]  CAUSE_NONE    = 3'd0;
    localparam logic [2:0]  CAUSE_HALTREQ = 3'd3;
    localparam logic [2:0]  CAUSE_STEP    = 3'd4;

    function automatic logic is_csr(input logic [15:0] regno);
        return (regno == REG_DCSR) || (regno == REG_DPC) ||
               (regno == REG_DSCRATCH0) || (regno == REG_MISA);
    endfunction

    // GPR window is 32 registers starting at GPR_BASE (0x1000-0x101F)
    function automatic logic is_gpr(input logic [15:0] regno);
        return regno[15:5] == GPR_BASE[15:5];
    endfunction

    function automatic logic [31:0] dcsr_pack(input logic [2:0] cause,
                                              input logic       step,
                                              input logic [1:0] prv);
        logic [31:0] v;
        v = 32'd0;
        v[DCSR_VER_LSB +: 4]   = DCSR_XDEBUGVER;
        v[DCSR_CAUSE_LSB +: 3] = cause;
        v[DCSR_STEP_BIT]       = step;
        v[DCSR_PRV_LSB +: 2]   = prv;
        return v;
    endfunction

endpackage

// File: rtl/debug_hart_csr.sv
// -----------------------------------------------------------------------------
// debug_hart_csr
// Storage for dcsr (cause/step/prv), dpc and dscratch0 plus the combinational
// CSR read mux (misa is a constant parameter).
// Ports: clk, rst_n; capture/capture_pc/capture_cause load dpc and dcsr.cause
// on halt entry; wr_en/wr_addr/wr_data perform abstract CSR writes; rd_addr ->
// rd_data read mux; dpc and step are exported to the hart FSM.
// Optional feature macro: DEBUG_HART_STEP_EN makes dcsr.step writable.
// -----------------------------------------------------------------------------
module debug_hart_csr
    import debug_pkg::*;
#(
    parameter logic [31:0] MISA_VALUE = 32'h4000_1105,
    parameter logic [1:0]  DCSR_PRV   = 2'b11
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        capture,
    input  logic [31:0] capture_pc,
    input  logic [2:0]  capture_cause,
    input  logic        wr_en,
    input  logic [15:0] wr_addr,
    input  logic [31:0] wr_data,
    input  logic [15:0] rd_addr,
    output logic [31:0] rd_data,
    output logic [31:0] dpc,
    output logic        step
);

    logic [31:0] dpc_r;
    logic [31:0] dscratch0_r;
    logic [2:0]  cause_r;
    logic [1:0]  prv_r;

    // dpc/cause are loaded on halt entry; abstract writes only happen in HALT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dpc_r       <= 32'd0;
            dscratch0_r <= 32'd0;
            cause_r     <= CAUSE_NONE;
            prv_r       <= DCSR_PRV;
        end else begin
            if (capture) begin
                dpc_r   <= capture_pc;
                cause_r <= capture_cause;
            end else if (wr_en && (wr_addr == REG_DPC)) begin
                dpc_r <= wr_data;
            end
            if (wr_en && (wr_addr == REG_DSCRATCH0)) begin
                dscratch0_r <= wr_data;
            end
            if (wr_en && (wr_addr == REG_DCSR)) begin
                prv_r <= wr_data[DCSR_PRV_LSB +: 2];
            end
        end
    end

`ifdef DEBUG_HART_STEP_EN
    logic step_r;

    // dcsr.step storage, only present when single-step is built in
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_r <= 1'b0;
        end else if (wr_en && (wr_addr == REG_DCSR)) begin
            step_r <= wr_data[DCSR_STEP_BIT];
        end
    end
    assign step = step_r;
`else
    assign step = 1'b0;
`endif

    // CSR read mux; unknown regnos read zero
    always_comb begin
        rd_data = 32'd0;
        case (rd_addr)
            REG_DCSR:      rd_data = dcsr_pack(cause_r, step, prv_r);
            REG_DPC:       rd_data = dpc_r;
            REG_DSCRATCH0: rd_data = dscratch0_r;
            REG_MISA:      rd_data = MISA_VALUE;
            default:       rd_data = 32'd0;
        endcase
    end

    assign dpc = dpc_r;

endmodule

// File: rtl/debug_hart_ctrl.sv
// -----------------------------------------------------------------------------
// debug_hart_ctrl
// Per-hart debug controller: halt/resume FSM (RUN, HALTING, HALT, RESUMING and
// optionally STEP), abstract register access to debug CSRs and GPRs.
// Ports: clk/rst_n; haltreq/resumereq in, halted/running/resumeack out;
// abstract access ar_en/ar_wr/ar_ad/ar_do in, ar_di/ar_ack/ar_err out;
// core side core_stall/core_redirect/core_newpc out, core_idle/core_pc/
// core_retire in; GPR port gpr_re/gpr_we/gpr_ad/gpr_wdata out, gpr_rdata in.
// Optional feature macro: DEBUG_HART_STEP_EN enables dcsr.step single-step.
// -----------------------------------------------------------------------------
module debug_hart_ctrl
    import debug_pkg::*;
#(
    parameter logic [31:0] MISA_VALUE = 32'h4000_1105,
    parameter logic [1:0]  DCSR_PRV   = 2'b11
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        haltreq,
    input  logic        resumereq,
    output logic        halted,
    output logic        running,
    output logic        resumeack,
    input  logic        ar_en,
    input  logic        ar_wr,
    input  logic [15:0] ar_ad,
    input  logic [31:0] ar_do,
    output logic [31:0] ar_di,
    output logic        ar_ack,
    output logic        ar_err,
    output logic        core_stall,
    input  logic        core_idle,
    input  logic [31:0] core_pc,
    input  logic        core_retire,
    output logic        core_redirect,
    output logic [31:0] core_newpc,
    output logic        gpr_re,
    output logic        gpr_we,
    output logic [4:0]  gpr_ad,
    output logic [31:0] gpr_wdata,
    input  logic [31:0] gpr_rdata
);

    hart_state_e state_r, state_next_s;
    logic [2:0]  cause_r, cause_next_s;
    logic        capture_s, run_next_s, step_s;
    logic [31:0] dpc_s, csr_rdata_s;
    logic        halted_r, running_r, resumeack_r, core_stall_r, core_redirect_r;
    logic        ar_ack_r, ar_err_r, gpr_pend_r;
    logic [31:0] ar_di_r;
    logic        busy_s, accept_s, bad_s, gpr_acc_s, csr_we_s;

    // Hart FSM next state; haltreq always dominates resumereq
    always_comb begin
        state_next_s = state_r;
        cause_next_s = cause_r;
        capture_s    = 1'b0;
        case (state_r)
            ST_RUN: begin
                if (haltreq) begin
                    state_next_s = ST_HALTING;
                    cause_next_s = CAUSE_HALTREQ;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_HALTING: begin
                if (core_idle) begin
                    capture_s    = 1'b1;
                    state_next_s = ST_HALT;
                end else begin
                    state_next_s = ST_HALTING;
                end
            end
            ST_HALT: begin
                if (resumereq && !haltreq) begin
                    state_next_s = ST_RESUMING;
                end else begin
                    state_next_s = ST_HALT;
                end
            end
            ST_RESUMING: begin
`ifdef DEBUG_HART_STEP_EN
                if (step_s) begin
                    state_next_s = ST_STEP;
                end else begin
                    state_next_s = ST_RUN;
                end
`else
                state_next_s = ST_RUN;
`endif
            end
`ifdef DEBUG_HART_STEP_EN
            ST_STEP: begin
                if (haltreq) begin
                    state_next_s = ST_HALTING;
                    cause_next_s = CAUSE_HALTREQ;
                end else if (core_retire) begin
                    state_next_s = ST_HALTING;
                    cause_next_s = CAUSE_STEP;
                end else begin
                    state_next_s = ST_STEP;
                end
            end
`endif
            default: state_next_s = ST_RUN;
        endcase
    end

`ifdef DEBUG_HART_STEP_EN
    assign run_next_s = (state_next_s == ST_RUN) || (state_next_s == ST_STEP);
`else
    assign run_next_s = (state_next_s == ST_RUN);
    logic unused_s;
    assign unused_s = ^{core_retire, step_s};
`endif

    // FSM state and latched halt cause
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_RUN;
            cause_r <= CAUSE_NONE;
        end else begin
            state_r <= state_next_s;
            cause_r <= cause_next_s;
        end
    end

    // Status/core outputs registered from the next state so they line up
    // with the state they describe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halted_r        <= 1'b0;
            running_r       <= 1'b1;
            core_stall_r    <= 1'b0;
            core_redirect_r <= 1'b0;
            resumeack_r     <= 1'b0;
        end else begin
            halted_r        <= (state_next_s == ST_HALT);
            running_r       <= run_next_s;
            core_stall_r    <= (state_next_s == ST_HALTING) || (state_next_s == ST_HALT);
            core_redirect_r <= (state_next_s == ST_RESUMING);
            if (state_next_s == ST_RESUMING) begin
                resumeack_r <= 1'b1;
            end else if (!resumereq) begin
                resumeack_r <= 1'b0;
            end else begin
                resumeack_r <= resumeack_r;
            end
        end
    end

    // Abstract access decode. The ack cycle also counts as busy so a new
    // strobe is only taken once the previous access has fully completed.
    assign busy_s    = ar_ack_r || gpr_pend_r;
    assign accept_s  = ar_en && !busy_s;
    assign bad_s     = (state_r != ST_HALT) || !(is_csr(ar_ad) || is_gpr(ar_ad)) ||
                       (ar_wr && (ar_ad == REG_MISA));
    assign gpr_acc_s = accept_s && !bad_s && is_gpr(ar_ad);
    assign csr_we_s  = accept_s && !bad_s && ar_wr && is_csr(ar_ad);

    // GPR strobes go out in the accept cycle so read data returns in time
    // to be registered into ar_di for the +2 acknowledge
    assign gpr_re    = gpr_acc_s && !ar_wr;
    assign gpr_we    = gpr_acc_s && ar_wr;
    assign gpr_ad    = ar_ad[4:0];
    assign gpr_wdata = ar_do;

    // Access completion: ack/err pulses and registered read data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ar_ack_r   <= 1'b0;
            ar_err_r   <= 1'b0;
            gpr_pend_r <= 1'b0;
            ar_di_r    <= 32'd0;
        end else begin
            ar_ack_r   <= 1'b0;
            ar_err_r   <= 1'b0;
            gpr_pend_r <= 1'b0;
            if (gpr_pend_r) begin
                ar_ack_r <= 1'b1;
                ar_di_r  <= gpr_rdata;
            end else if (accept_s) begin
                if (bad_s) begin
                    ar_ack_r <= 1'b1;
                    ar_err_r <= 1'b1;
                    ar_di_r  <= 32'd0;
                end else if (is_gpr(ar_ad) && !ar_wr) begin
                    gpr_pend_r <= 1'b1;
                end else begin
                    // CSR read/write or GPR write; writes return zero data
                    ar_ack_r <= 1'b1;
                    ar_di_r  <= ar_wr ? 32'd0 : csr_rdata_s;
                end
            end else begin
                ar_di_r <= ar_di_r;
            end
        end
    end

    debug_hart_csr #(
        .MISA_VALUE (MISA_VALUE),
        .DCSR_PRV   (DCSR_PRV)
    ) u_csr (
        .clk           (clk),
        .rst_n         (rst_n),
        .capture       (capture_s),
        .capture_pc    (core_pc),
        .capture_cause (cause_r),
        .wr_en         (csr_we_s),
        .wr_addr       (ar_ad),
        .wr_data       (ar_do),
        .rd_addr       (ar_ad),
        .rd_data       (csr_rdata_s),
        .dpc           (dpc_s),
        .step          (step_s)
    );

    assign halted        = halted_r;
    assign running       = running_r;
    assign resumeack     = resumeack_r;
    assign core_stall    = core_stall_r;
    assign core_redirect = core_redirect_r;
    assign core_newpc    = dpc_s;
    assign ar_ack        = ar_ack_r;
    assign ar_err        = ar_err_r;
    assign ar_di         = ar_di_r;

endmodule

// File: doc/debug_hart_ctrl.md
DEBUG_HART_CTRL -- requirements
Module: debug_hart_ctrl

Interface
REQ-001 SHALL have parameter MISA_VALUE, default 32'h4000_1105, the value returned for abstract reads of misa (0x0301).
REQ-002 SHALL have parameter DCSR_PRV, default 2'b11, the reset value of dcsr.prv.
REQ-003 SHALL have one clock and an asynchronous, active-low reset (already decided): CLK input 1, rising-edge clock; RST_N input 1, async active-low reset.
REQ-004 SHALL have the debug-module halt/resume ports: HALTREQ in 1 halt request (level); RESUMEREQ in 1 resume request (level); HALTED out 1 hart halted; RUNNING out 1 hart running; RESUMEACK out 1 resume acknowledged.
REQ-005 SHALL have the abstract-register ports: AR_EN in 1 access strobe; AR_WR in 1 1=write; AR_AD in 16 regno; AR_DO in 32 write data from DM; AR_DI out 32 read data to DM; AR_ACK out 1 completion pulse; AR_ERR out 1 error, valid with AR_ACK.
REQ-006 SHALL have the core-side ports: CORE_STALL out 1 freeze fetch; CORE_IDLE in 1 pipeline drained; CORE_PC in 32 next-PC; CORE_RETIRE in 1 instruction retired; CORE_REDIRECT out 1 one-cycle PC load; CORE_NEWPC out 32 redirect target.
REQ-007 SHALL have the GPR port: GPR_RE out 1; GPR_WE out 1; GPR_AD out 5; GPR_WDATA out 32; GPR_RDATA in 32, valid one cycle after GPR_RE.

Function
REQ-008 SHALL implement FSM states RUN, HALTING, HALT, RESUMING, STEP.
REQ-009 RUN: HALTREQ=1 -> HALTING, latching cause=3; CORE_STALL asserts in the cycle after HALTREQ is sampled.
REQ-010 HALTING: CORE_STALL=1; on CORE_IDLE=1 capture dpc<=CORE_PC, dcsr.cause<=latched cause -> HALT; HALTED=1 from the following cycle.
REQ-011 HALT: CORE_STALL=1, HALTED=1; RESUMEREQ=1 with HALTREQ=0 -> RESUMING.
REQ-012 RESUMING: single-cycle state; pulse CORE_REDIRECT with CORE_NEWPC=dpc, deassert CORE_STALL, set RESUMEACK -> RUN, or STEP when dcsr.step=1 (only if DEBUG_HART_STEP_EN).
REQ-013 RESUMEACK SHALL stay high until RESUMEREQ is sampled low, then clear.
REQ-014 HALTREQ SHALL win when HALTREQ and RESUMEREQ are asserted together in any state.
REQ-015 HALTREQ in HALT and RESUMEREQ in RUN SHALL have no effect.
REQ-016 RUNNING SHALL equal state==RUN||STEP.
REQ-017 Abstract access SHALL be accepted only in HALT; one access in flight; AR_EN while busy ignored.
REQ-018 CSR access (0x07B0 dcsr, 0x07B1 dpc, 0x07B2 dscratch0, 0x0301 misa) SHALL raise AR_ACK one cycle after AR_EN, with AR_DI registered.
REQ-019 GPR access (0x1000-0x101F) SHALL drive GPR_AD=AR_AD[4:0]; write: GPR_WE pulse, AR_ACK +1 cycle; read: GPR_RE pulse, AR_ACK +2 cycles, AR_DI=GPR_RDATA.
REQ-020 Any other regno, a write to misa, or any access outside HALT SHALL give AR_ACK with AR_ERR=1 and AR_DI=0.
REQ-021 dcsr SHALL read xdebugver[31:28]=4, cause[8:6], step[2], prv[1:0]; only step and prv are writable; all other bits read 0.
REQ-022 AR_ACK, AR_ERR, GPR_RE, GPR_WE and CORE_REDIRECT SHALL be single-cycle pulses.

Reset
REQ-023 On reset: state=RUN, RUNNING=1, HALTED=0, RESUMEACK=0, CORE_STALL=0, all pulses=0, AR_DI=0, dpc=0, dscratch0=0, dcsr.cause=0, step=0, prv=DCSR_PRV.
REQ-024 Reset mid-halt or mid-access SHALL abort to RUN immediately without generating an AR_ACK.

Configuration
REQ-025 With macro DEBUG_HART_STEP_EN defined: STEP state; deassert CORE_STALL until the first CORE_RETIRE, then reassert it and enter HALTING with cause=4; HALTREQ during STEP takes cause=3.
REQ-026 Without it: dcsr.step reads 0 and ignores writes, and STEP is absent.

Structure
REQ-027 Package debug_pkg SHALL hold FSM state enum, regno constants (CSR addresses, GPR base), dcsr field positions and cause codes.
REQ-028 Sub-module debug_hart_csr SHALL hold dcsr/dpc/dscratch0 storage and the read mux.

Verification
REQ-029 HALTREQ=1, CORE_IDLE after 3 cycles, CORE_PC=0x8000_0100 -> HALTED=1, dpc read=0x8000_0100, dcsr read=0x4000_00C3.
REQ-030 In HALT, write dpc=0x8000_0200, RESUMEREQ=1 -> CORE_REDIRECT pulse, CORE_NEWPC=0x8000_0200, RESUMEACK=1 until RESUMEREQ=0.
REQ-031 Read 0x1005 with GPR_RDATA=0xDEAD_BEEF -> GPR_AD=5, AR_ACK 2 cycles after AR_EN, AR_DI=0xDEAD_BEEF, AR_ERR=0.
REQ-032 Read 0x0301 -> 0x4000_1105; write 0x0301 or access 0x2000 -> AR_ERR=1, AR_DI=0; any access while RUN -> AR_ERR=1.
REQ-033 HALTREQ and RESUMEREQ raised together while in HALT -> remains halted, no CORE_REDIRECT.
REQ-034 With DEBUG_HART_STEP_EN: dcsr.step=1, resume, one CORE_RETIRE -> re-halt, cause=4; RST_N low mid-access -> RUNNING=1, no AR_ACK.
